// File: rtl/signal_sequencer.sv
// Commanded playback sequencer for the waveform ROM: steps the read address by a
// programmable increment for a bounded (or continuous) number of table periods.
`timescale 1ns/1ps
module signal_sequencer #(
  parameter int NB_SEL   = 2,
  parameter int NB_COUNT = 10,
  parameter int NB_STEP  = 4,
  parameter int NB_BURST = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [NB_SEL-1:0]   i_cmd_sel,
  input  logic [NB_STEP-1:0]  i_cmd_step,
  input  logic [NB_BURST-1:0] i_cmd_periods,
  input  logic                i_stop,
  output logic [NB_COUNT-1:0] o_addr,
  output logic [NB_SEL-1:0]   o_sel,
  output logic                o_valid,
  output logic                o_done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [NB_STEP-1:0]  step;
  logic [NB_BURST-1:0] remaining;
  logic [NB_COUNT:0]   next_addr;
  logic                carry;

  // One extra bit on the adder exposes the table wrap as a carry
  assign next_addr   = {1'b0, o_addr} + {{(NB_COUNT + 1 - NB_STEP){1'b0}}, step};
  assign carry       = next_addr[NB_COUNT];
  assign o_cmd_ready = (state == IDLE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      o_addr    <= '0;
      o_sel     <= '0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      step      <= NB_STEP'(1);
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done  <= 1'b0;
          o_valid <= 1'b0;
          o_addr  <= '0;
          if (i_cmd_valid) begin
            state     <= RUN;
            o_valid   <= 1'b1;
            o_sel     <= i_cmd_sel;
            step      <= (i_cmd_step == '0) ? NB_STEP'(1) : i_cmd_step;
            remaining <= i_cmd_periods;
          end
        end
        RUN: begin
          o_done <= 1'b0;
          // A stop beats the final carry, so an aborted burst never reports done
          if (i_stop) begin
            state   <= IDLE;
            o_addr  <= '0;
            o_valid <= 1'b0;
          end else if (carry && remaining == NB_BURST'(1)) begin
            state   <= IDLE;
            o_addr  <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            o_addr <= next_addr[NB_COUNT-1:0];
            // remaining == 0 marks continuous playback and is left untouched
            if (carry && remaining != '0)
              remaining <= remaining - NB_BURST'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_sequencer.sv
// Self-checking bench for signal_sequencer: directed scenarios plus randomized
// bursts, all compared every cycle against an unwrapped-position playback model.
`timescale 1ns/1ps
module tb_signal_sequencer;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_sel = '0;
  logic [3:0] cmd_step = '0;
  logic [7:0] cmd_periods = '0;
  logic       stop = 1'b0;
  logic [9:0] addr;
  logic [1:0] sel;
  logic       valid;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  signal_sequencer dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_sel    (cmd_sel),
    .i_cmd_step   (cmd_step),
    .i_cmd_periods(cmd_periods),
    .i_stop       (stop),
    .o_addr       (addr),
    .o_sel        (sel),
    .o_valid      (valid),
    .o_done       (done)
  );

  always #5 i_clock = ~i_clock;

  // Playback model: tracks the unwrapped position; a burst ends once it reaches P*1024
  bit       m_run = 1'b0;
  int       m_u = 0;
  int       m_s = 1;
  int       m_p = 0;
  bit [1:0] m_sel = '0;
  bit       m_done = 1'b0;

  always @(posedge i_clock) begin
    if (i_reset) begin
      m_run = 1'b0; m_u = 0; m_sel = '0; m_done = 1'b0;
    end else if (!m_run) begin
      m_done = 1'b0;
      if (cmd_valid) begin
        m_run = 1'b1;
        m_u   = 0;
        m_s   = (cmd_step == 4'd0) ? 1 : int'(cmd_step);
        m_p   = int'(cmd_periods);
        m_sel = cmd_sel;
      end
    end else begin
      m_done = 1'b0;
      if (stop) begin
        m_run = 1'b0; m_u = 0;
      end else begin
        m_u = m_u + m_s;
        if (m_p != 0 && m_u >= m_p * 1024) begin
          m_run = 1'b0; m_u = 0; m_done = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("cmd_ready", int'(cmd_ready), int'(!m_run));
    cmp("valid", int'(valid), int'(m_run));
    cmp("addr", int'(addr), m_run ? (m_u % 1024) : 0);
    cmp("sel", int'(sel), int'(m_sel));
    cmp("done", int'(done), int'(m_done));
  endtask

  always @(negedge i_clock) if (check_en) checkOutput();

  // Issues one command at a negedge; returns at the negedge showing the first sample
  task automatic applyStimulus(input int s_sel, input int s_step, input int s_per);
    @(negedge i_clock);
    cmd_sel     = 2'(s_sel);
    cmd_step    = 4'(s_step);
    cmd_periods = 8'(s_per);
    cmd_valid   = 1'b1;
    @(negedge i_clock);
    cmd_valid   = 1'b0;
  endtask

  // Counts valid samples until done (relative cycle k from first sample = 1)
  task automatic runBurst(input int limit, input bit noisy, output int nvalid, output int done_at);
    int k = 1;
    nvalid = 0; done_at = 0;
    while (k <= limit) begin
      if (done) begin done_at = k; break; end
      if (valid) nvalid++;
      if (noisy) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_sel   = 2'($urandom_range(0, 3));
        cmd_step  = 4'($urandom_range(0, 15));
      end
      @(negedge i_clock);
      k++;
    end
    cmd_valid = 1'b0;
    if (done_at == 0) cmp("burst_timeout", 0, 1);
  endtask

  task automatic waitAddr(input int target, input int limit);
    int k = 0;
    while (!(valid && int'(addr) == target) && k < limit) begin
      @(negedge i_clock);
      k++;
    end
    if (k >= limit) cmp("wait_addr_timeout", int'(addr), target);
  endtask

  initial begin
    int nvalid, done_at, zeros;
    $display("[TB] start");
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check_en = 1'b1;
    cmp("reset_ready", int'(cmd_ready), 1);
    cmp("reset_valid", int'(valid), 0);
    cmp("reset_addr", int'(addr), 0);
    i_reset = 1'b0;

    // sel=2 step=1 periods=1: 1024 samples, done at T+1025
    applyStimulus(2, 1, 1);
    cmp("t1_first_addr", int'(addr), 0);
    cmp("t1_first_sel", int'(sel), 2);
    runBurst(1100, 1'b0, nvalid, done_at);
    cmp("t1_nvalid", nvalid, 1024);
    cmp("t1_done_at", done_at, 1025);
    @(negedge i_clock);
    cmp("t1_done_clear", int'(done), 0);

    // step=4 periods=2 with cmd_valid noise during RUN
    applyStimulus(1, 4, 2);
    runBurst(600, 1'b1, nvalid, done_at);
    cmp("t2_nvalid", nvalid, 512);
    @(negedge i_clock);

    // step=0 behaves as step=1
    applyStimulus(3, 0, 1);
    runBurst(1100, 1'b0, nvalid, done_at);
    cmp("t3_step0_nvalid", nvalid, 1024);
    @(negedge i_clock);

    // step=3: 342 samples ending at 1023
    applyStimulus(0, 3, 1);
    waitAddr(1023, 400);
    @(negedge i_clock);
    cmp("t3_step3_done", int'(done), 1);
    applyStimulus(0, 3, 1);
    runBurst(400, 1'b0, nvalid, done_at);
    cmp("t3_step3_nvalid", nvalid, 342);
    @(negedge i_clock);

    // continuous step=8, stop issued in cycle 300
    applyStimulus(1, 8, 0);
    zeros = 0;
    for (int k = 1; k <= 300; k++) begin
      if (valid && addr == 10'd0) zeros++;
      if (k == 300) stop = 1'b1;
      @(negedge i_clock);
    end
    stop = 1'b0;
    cmp("t4_wraps", zeros, 3);
    cmp("t4_stop_valid", int'(valid), 0);
    cmp("t4_stop_addr", int'(addr), 0);
    cmp("t4_stop_done", int'(done), 0);
    cmp("t4_stop_ready", int'(cmd_ready), 1);

    // reset mid-RUN at addr 500, then restart from 0
    applyStimulus(2, 1, 1);
    waitAddr(500, 600);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    cmp("t5_rst_valid", int'(valid), 0);
    cmp("t5_rst_sel", int'(sel), 0);
    cmp("t5_rst_done", int'(done), 0);
    applyStimulus(1, 2, 1);
    cmp("t5_restart_addr", int'(addr), 0);
    runBurst(600, 1'b0, nvalid, done_at);
    cmp("t5_restart_nvalid", nvalid, 512);
    @(negedge i_clock);

    // stop on the final-carry cycle suppresses done
    applyStimulus(3, 1, 1);
    waitAddr(1023, 1100);
    stop = 1'b1;
    @(negedge i_clock);
    stop = 1'b0;
    cmp("t6_stop_valid", int'(valid), 0);
    cmp("t6_stop_done", int'(done), 0);
    @(negedge i_clock);
    cmp("t6_stop_done_after", int'(done), 0);

    // randomized bursts with random stops, idle stops and command noise
    for (int it = 0; it < 14; it++) begin
      int per, lim;
      stop = 1'b1;
      @(negedge i_clock);
      stop = 1'b0;
      per = $urandom_range(0, 2);
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 15), per);
      lim = 0;
      while (valid && lim < 2500) begin
        stop      = ($urandom_range(0, 399) == 0);
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_step  = 4'($urandom_range(0, 15));
        @(negedge i_clock);
        lim++;
      end
      cmd_valid = 1'b0;
      stop = valid;
      @(negedge i_clock);
      stop = 1'b0;
      @(negedge i_clock);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/signal_sequencer.md
# signal_sequencer

Controller that sequences the waveform ROM read address of the signal generator. It accepts a playback command (table select, address step, number of table periods), then drives the table select and ROM address every cycle until the burst completes or is stopped. It sits between the control/register logic and the ROM bank. It replaces a free-running address counter with a commanded, frequency-scalable, bounded playback.

## Interface
- NB_SEL, 2, width of waveform table select
- NB_COUNT, 10, ROM address width (table depth 2^NB_COUNT)
- NB_STEP, 4, width of address increment per cycle
- NB_BURST, 8, width of period count

- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high in IDLE; a command is accepted on a cycle where i_cmd_valid & o_cmd_ready
- i_cmd_sel  in  NB_SEL  table to play, sampled on accept
- i_cmd_step  in  NB_STEP  address increment per cycle, sampled on accept; 0 is treated as 1
- i_cmd_periods  in  NB_BURST  table wraps to play, sampled on accept; 0 means continuous
- i_stop  in  1  abort playback; used only in RUN
- o_addr  out  NB_COUNT  ROM read address
- o_sel  out  NB_SEL  latched table select
- o_valid  out  1  high while o_addr/o_sel are a playing sample
- o_done  out  1  one-cycle pulse on natural burst completion

## Operation
- Two states: IDLE, RUN. The state register, o_addr, o_sel, o_valid, o_done, step, and remaining-period registers are all clocked.
- Reset values: state IDLE, o_addr 0, o_sel 0, o_valid 0, o_done 0, o_cmd_ready 1.
- IDLE: o_cmd_ready=1 (decoded from state), o_valid=0, o_addr held at 0.
  - On accept: latch sel, step (0→1), and periods.
  - Go to RUN with o_addr=0.
- RUN: o_cmd_ready=0, o_valid=1.
  - Each cycle: next address = o_addr + step, computed NB_COUNT+1 bits wide. Bit NB_COUNT is the wrap carry. o_addr takes the low NB_COUNT bits (modulo 2^NB_COUNT).
  - On carry with finite burst: remaining decrements. If remaining was 1, go to IDLE, o_addr←0, o_done=1 for that next cycle.
  - Continuous mode (periods=0) never ends by itself; the remaining counter is not decremented.
- i_stop in RUN: next cycle IDLE, o_addr 0, o_valid 0, no o_done.
- i_stop in IDLE: ignored.
- i_stop together with the final carry: stop wins, no o_done.
- i_cmd_valid in RUN: ignored, not queued. The requester holds valid until ready.
- i_reset has priority over everything. Reset mid-RUN aborts next edge to reset values, no o_done.

## Timing
- Accept at edge T: the first sample (o_addr=0, o_valid=1, o_sel=new) is visible after T, i.e. in cycle T+1.
- o_addr advances by step every cycle in RUN. There are no stall cycles.
- A finite burst of P periods produces exactly the samples whose unwrapped address < P·2^NB_COUNT.
- The cycle after the last valid sample has o_valid=0, o_done=1, o_cmd_ready=1. A new command can be accepted in that same cycle. The earliest restart is one idle cycle after the last sample.
- ROM latency is external. Consumers align o_valid/o_sel with ROM output themselves.

## Test plan
- sel=2, step=1, periods=1 accepted at T → o_valid high cycles T+1..T+1024, o_addr 0..1023, o_sel=2; o_done=1 at T+1025, then o_valid=0.
- step=4, periods=2 → 512 valid cycles, o_addr 0,4,…,1020,0,…,1020; single o_done after last sample; cmd_valid pulses during RUN get ready=0 and no effect.
- step=0, periods=1 → behaves exactly as step=1 (1024 samples). step=3, periods=1 → 342 samples 0,3,…,1023, then done.
- periods=0, step=8 → o_addr wraps 1016→0 repeatedly with no o_done; i_stop at cycle 300 → next cycle o_valid=0, o_addr=0, o_done=0, o_cmd_ready=1.
- i_reset asserted mid-RUN (o_addr=500) → next cycle all outputs at reset values; a new command after reset starts from o_addr 0.
- i_stop asserted on the final-carry cycle of periods=1 → IDLE next cycle, o_done stays 0.
